// File: rtl/pal_rb_pkg.sv
// Shared types and constants for the PAL configuration readback transmitter.
// The CRC state exists only when PAL_RB_CRC_EN is defined.
package pal_rb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SHIFT,
`ifdef PAL_RB_CRC_EN
    CRC,
`endif
    DONE
  } rb_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

endpackage

// File: rtl/pal_rb_crc8.sv
// Bit-serial CRC-8 (MSB-first, no reflection, no final XOR) for the readback frame.
// Compiled only when PAL_RB_CRC_EN is defined; feeding bit_in = crc[7] shifts the CRC out.
`ifdef PAL_RB_CRC_EN
module pal_rb_crc8
  import pal_rb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  always_comb begin
    crc_d = {crc_q[6:0], 1'b0};
    if (crc_q[7] ^ bit_in) begin
      crc_d = crc_d ^ CRC8_POLY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC8_INIT;
    end else if (clr) begin
      crc_q <= CRC8_INIT;
    end else if (en) begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule
`endif

// File: rtl/pal_cfg_readback.sv
// Serial readback of the PAL configuration memory, MSB-first over a valid/ready bit link.
// Define PAL_RB_CRC_EN to append a CRC-8 trailer after the last data bit.
module pal_cfg_readback
  import pal_rb_pkg::*;
#(
  parameter  int NUM_WORDS = 32,
  parameter  int WORD_W    = 8,
  localparam int ADDR_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              sdo,
  output logic              sdo_valid,
  input  logic              sdo_ready,
  output logic              busy,
  output logic              done
);

  // Counter must reach WORD_W (data) and also count the 8 CRC bits.
  localparam int CNT_MAX = (WORD_W > 8) ? WORD_W : 8;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  rb_state_e         state_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [WORD_W-1:0] shreg_q;
  logic              mem_rd_q;
  logic              sdo_valid_q;
  logic              busy_q;
  logic              done_q;

  logic xfer;
  logic last_bit;
  logic last_word;

  assign xfer      = ena && sdo_valid_q && sdo_ready;
  assign last_bit  = (bit_cnt_q == CNT_W'(WORD_W - 1));
  assign last_word = (word_idx_q == ADDR_W'(NUM_WORDS - 1));

`ifdef PAL_RB_CRC_EN
  logic [7:0] crc_w;
  logic       crc_clr;
  logic       crc_en;

  assign crc_clr = ena && (state_q == IDLE) && start;
  assign crc_en  = xfer && ((state_q == SHIFT) || (state_q == CRC));

  pal_rb_crc8 u_crc8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (sdo),
    .crc    (crc_w)
  );

  assign sdo = (state_q == CRC) ? crc_w[7] : shreg_q[WORD_W-1];
`else
  assign sdo = shreg_q[WORD_W-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_idx_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      mem_rd_q    <= 1'b0;
      sdo_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (ena) begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= FETCH;
            word_idx_q <= '0;
            mem_rd_q   <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        FETCH: begin
          state_q  <= WAIT;
          mem_rd_q <= 1'b0;
        end
        WAIT: begin
          state_q     <= SHIFT;
          shreg_q     <= mem_rdata;
          bit_cnt_q   <= '0;
          sdo_valid_q <= 1'b1;
        end
        SHIFT: begin
          if (xfer) begin
            shreg_q   <= shreg_q << 1;
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (last_bit) begin
              if (last_word) begin
`ifdef PAL_RB_CRC_EN
                state_q   <= CRC;
                bit_cnt_q <= '0;
`else
                state_q     <= DONE;
                sdo_valid_q <= 1'b0;
                done_q      <= 1'b1;
`endif
              end else begin
                state_q     <= FETCH;
                word_idx_q  <= word_idx_q + ADDR_W'(1);
                mem_rd_q    <= 1'b1;
                sdo_valid_q <= 1'b0;
              end
            end
          end
        end
`ifdef PAL_RB_CRC_EN
        CRC: begin
          if (xfer) begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              state_q     <= DONE;
              sdo_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Frozen while ena is low: strobes are masked, everything else holds.
  assign mem_rd    = mem_rd_q & ena;
  assign sdo_valid = sdo_valid_q & ena;
  assign mem_addr  = word_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/pal_cfg_readback.md
# pal_cfg_readback

Serial readback transmitter for the PAL fuse/configuration memory inside `tt_um_MATTHIAS_M_PAL_TOP_WRAPPER`. The configuration loader writes the fuse map in. This block is the opposite direction: it reads the map back word-by-word through a synchronous read port and streams it out MSB-first over a valid/ready bit interface. Its purpose is post-programming verification from the tile pins. It sits beside the config loader and shares the memory read port with the PAL array when the array is idle.

## Interface
Parameters:
- `NUM_WORDS`, default 32: number of configuration words read back.
- `WORD_W`, default 8: configuration word width.
- `ADDR_W`, derived as `$clog2(NUM_WORDS)`: localparam, not overridable.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: tile enable. When low, the block freezes (see Operation).
- `start` in 1: sampled in IDLE only; begins a readback frame.
- `mem_rd` out 1: read strobe to config memory.
- `mem_addr` out ADDR_W: read address.
- `mem_rdata` in WORD_W: read data, valid exactly one cycle after `mem_rd`.
- `sdo` out 1: serial data bit.
- `sdo_valid` out 1: `sdo` holds a valid bit.
- `sdo_ready` in 1: consumer accepts the bit. A transfer occurs on `sdo_valid && sdo_ready` at a rising edge.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at end of frame.

## Operation
- FSM states: IDLE, FETCH, WAIT, SHIFT, CRC (only when macro defined), DONE.
- IDLE: `start` high moves the FSM to FETCH. Word index is cleared to 0.
- FETCH, one cycle: `mem_rd`=1, `mem_addr`=word index. Next state is WAIT.
- WAIT, one cycle: `mem_rdata` is loaded into the WORD_W shift register and the bit counter is cleared. Next state is SHIFT.
- SHIFT:
  - `sdo_valid`=1 and `sdo`=shreg MSB.
  - On each transfer, shift left and increment the bit counter.
  - After the WORD_W-th transfer:
    - If word index = NUM_WORDS-1, go to CRC (macro) or DONE.
    - Otherwise, increment word index and go to FETCH.
- DONE, one cycle: `done`=1, then IDLE.
- Valid/ready rule: once `sdo_valid` rises, `sdo` stays stable until a transfer, as long as `ena` is high. There is no combinational path from `sdo_ready` to `sdo_valid`.
- `start` outside IDLE (including in the DONE cycle) is ignored. No queuing.
- `ena` low behaviour:
  - All registers hold.
  - `mem_rd` and `sdo_valid` are forced to 0.
  - No transfer is counted.
  - Operation resumes in place when `ena` returns high.
- Word index and bit counter never wrap within a frame. Word index is cleared on frame start.

## Timing
- Reset values: `mem_rd`=0, `mem_addr`=0, `sdo`=0, `sdo_valid`=0, `busy`=0, `done`=0. FSM is in IDLE. Shift register, counters and CRC are all 0.
- Reset asserted mid-frame: immediate return to reset values. No `done` is issued. The next `start` restarts at address 0.
- Latency counts edges after the edge that samples `start`, with `ena`=1 and `sdo_ready`=1 throughout:
  - `mem_rd` is high in cycle 1.
  - First `sdo_valid` is in cycle 3.
  - Each word costs WORD_W+2 cycles.
  - Without the macro, `done` is high in cycle NUM_WORDS*(WORD_W+2)+1.
  - With the macro, add 8 cycles.
- `busy` rises the cycle after `start` is sampled and falls the cycle after `done`.

## Configuration
- Macro: `PAL_RB_CRC_EN`.
- With `PAL_RB_CRC_EN` defined:
  - A CRC-8 accumulates over every transferred data bit, MSB-first. Polynomial is 0x07, init 0x00, no reflection, no final XOR.
  - After the last data bit, CRC state sends the 8 CRC bits MSB-first. These use the same valid/ready rules as data bits.
  - The CRC register clears on frame start.
- Without `PAL_RB_CRC_EN`:
  - No CRC state or logic.
  - The frame is exactly NUM_WORDS*WORD_W bits.

## Structure
- Package `pal_rb_pkg`:
  - FSM state enum.
  - `CRC8_POLY` = 8'h07.
  - `CRC8_INIT` = 8'h00.
- Sub-module `pal_rb_crc8`: bit-serial CRC-8 with ports `clk`, `rst_n`, `clr`, `en`, `bit_in`, `crc`. Instantiated only under `PAL_RB_CRC_EN`.

## Test plan
Unless stated otherwise, the bench uses NUM_WORDS=4, WORD_W=8 and memory {0xA5, 0x3C, 0xFF, 0x00}.
- Reset check: hold `rst_n` low, then release. All outputs are 0 and `busy`=0 for 10 idle cycles with no `start`.
- Full frame: pulse `start` with `sdo_ready`=1.
  - Bits are 10100101 00111100 11111111 00000000.
  - `mem_addr` steps 0,1,2,3.
  - First `sdo_valid` is at cycle 3.
  - `done` is a single pulse at cycle 41.
- Backpressure: drop `sdo_ready` for 5 cycles at bit 4 of word 1.
  - `sdo_valid` stays 1 and `sdo` is stable.
  - The stream is identical to the full-frame case and `done` is 5 cycles later.
- Busy and ena handling:
  - Pulse `start` again at cycle 10. It is ignored and `mem_addr` sequence is unchanged.
  - Drop `ena` for 3 cycles mid-SHIFT. `sdo_valid`=0 during the gap, and no bit is lost or duplicated.
- Reset mid-frame: assert `rst_n` low during word 2.
  - Outputs return to reset values and no `done` occurs.
  - A new `start` reads from address 0.
- CRC (`PAL_RB_CRC_EN`, NUM_WORDS=1, memory {0x01}):
  - Stream is 00000001 followed by CRC 00000111 (0x07).
  - `done` occurs at cycle 19.
